// File: rtl/and_vec_pkg.sv
// Shared types and helpers for the AND-datapath vector sequencer.
package and_vec_pkg;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} and_vec_state_t;

  localparam int unsigned ERR_W = 16;

  // Number of {a,b} vectors in one full sweep.
  function automatic int unsigned vec_total(input int unsigned width);
    return 32'd1 << (2 * width);
  endfunction

endpackage

// File: rtl/and_vec_gap_timer.sv
// Idle-gap down-counter: loaded on each transfer, counts down while in GAP,
// and flags expiry on the last idle cycle. Only built when GAP > 0.
module and_vec_gap_timer #(
  parameter int unsigned GAP = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(GAP + 1);
  // Loading GAP-1 makes the count reach zero on the GAP-th idle cycle.
  localparam logic [CW-1:0] LOAD_VAL = CW'(GAP - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = LOAD_VAL;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/and_vec_seq.sv
// Exhaustive {a,b} vector sequencer over a valid/ready handshake.
// Optional result checker enabled by defining AND_VEC_CHECK_EN.
module and_vec_seq
  import and_vec_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned GAP   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH:0]   vec_cnt_o
`ifdef AND_VEC_CHECK_EN
  ,
  input  logic [WIDTH-1:0]   res_i,
  output logic [ERR_W-1:0]   err_cnt_o
`endif
);

  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned CW = IW + 1;

  and_vec_state_t state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  vec_cnt_q, vec_cnt_d;
  logic           done_q, done_d;
  logic           start_ok, xfer, last_vec, in_gap, gap_expired;

  // Abort outranks both a pending transfer and a new start.
  assign start_ok = start_i && !abort_i && ((state_q == IDLE) || (state_q == DONE));
  assign xfer     = (state_q == RUN) && ready_i && !abort_i;
  assign last_vec = (idx_q == '1);
  assign in_gap   = (state_q == and_vec_pkg::GAP);

  // NOTE: non-blocking in always_ff so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: defaults first so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: if (start_i) state_d = RUN;
        RUN: begin
          if (xfer) begin
            if (last_vec)     state_d = DONE;
            else if (GAP > 0) state_d = and_vec_pkg::GAP;
            else              state_d = RUN;
          end
        end
        and_vec_pkg::GAP: if (gap_expired) state_d = RUN;
        default:          state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_o = (state_q == RUN);
    busy_o  = (state_q == RUN) || in_gap;
  end

  always_comb begin
    idx_d     = idx_q;
    vec_cnt_d = vec_cnt_q;
    done_d    = done_q;
    if (abort_i) begin
      done_d = 1'b0;
    end else if (start_ok) begin
      idx_d     = '0;
      vec_cnt_d = '0;
      done_d    = 1'b0;
    end else if (xfer) begin
      vec_cnt_d = vec_cnt_q + CW'(1);
      if (last_vec) done_d = 1'b1;
      else          idx_d  = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      vec_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      vec_cnt_q <= vec_cnt_d;
      done_q    <= done_d;
    end
  end

  assign {a_o, b_o} = idx_q;
  assign done_o     = done_q;
  assign vec_cnt_o  = vec_cnt_q;

  generate
    if (GAP > 0) begin : g_gap
      and_vec_gap_timer #(.GAP(GAP)) u_gap_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (xfer),
        .en_i      (in_gap),
        .expired_o (gap_expired)
      );
    end else begin : g_no_gap
      assign gap_expired = 1'b1;
    end
  endgenerate

`ifdef AND_VEC_CHECK_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // The AND stage is combinational, so its result is valid in the transfer cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (start_ok)
      err_cnt_d = '0;
    else if (xfer && (res_i != (a_o & b_o)) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule
